load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WAIT_MAX, default 15, SHALL set the maximum number of cycles spent in REQ plus WAIT before a timeout error.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 lsu_valid  input  1  SHALL indicate that a memory operation is presented.
REQ-005 lsu_we  input  1  SHALL select the operation: 1 = store, 0 = load.
REQ-006 lsu_funct3  input  3  SHALL carry the RISC-V width/sign code.
REQ-007 lsu_addr  input  32  SHALL carry the byte address, which is the ALU result.
REQ-008 lsu_wdata  input  32  SHALL carry the store data (rs2).
REQ-009 lsu_stall  output  1  SHALL hold the core's PC and register writes while an operation is pending.
REQ-010 lsu_done  output  1  SHALL be a one-cycle completion pulse.
REQ-011 lsu_rdata  output  32  SHALL carry the extended load result, valid only while lsu_done=1.
REQ-012 lsu_err  output  1  SHALL be asserted with lsu_done to flag misalignment, an illegal funct3 or a timeout.
REQ-013 mem_req, mem_we  output  1 each  SHALL form the memory request and its write flag.
REQ-014 mem_addr  output  32  SHALL be the word-aligned address {lsu_addr[31:2],2'b00}.
REQ-015 mem_be  output  4  SHALL be the byte enables.
REQ-016 mem_wdata  output  32  SHALL be the lane-replicated store data.
REQ-017 mem_gnt, mem_rvalid  input  1 each  SHALL be the memory's request accept and its response/write-ack.
REQ-018 mem_rdata  input  32  SHALL be the memory read word, valid when mem_rvalid=1.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, RESP.
REQ-020 The FSM SHALL use these transitions:
- IDLE with lsu_valid and a legal, aligned operation: latch all inputs, go to REQ.
- IDLE with lsu_valid and an illegal or misaligned operation: go to RESP with err set; no mem_req is issued.
- REQ: mem_req=1 and held stable until mem_gnt. On mem_gnt without mem_rvalid: go to WAIT. On mem_gnt with mem_rvalid in the same cycle: capture the response and go to RESP.
- WAIT: on mem_rvalid, capture mem_rdata and go to RESP.
- RESP: lsu_done=1 for one cycle, then return to IDLE.
REQ-021 Legal funct3 values SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. All other combinations SHALL be illegal.
REQ-022 Alignment SHALL require half accesses to have addr[0]=0 and word accesses to have addr[1:0]=00; byte accesses are always aligned.
REQ-023 mem_be SHALL be 4'b0001<<addr[1:0] for byte accesses, 4'b0011<<addr[1:0] for half accesses and 4'b1111 for word accesses. Loads SHALL also drive these enables.
REQ-024 mem_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH and wdata for SW.
REQ-025 Load data SHALL be mem_rdata >> (8*addr[1:0]), then sign-extended (LB, LH) or zero-extended (LBU, LHU) from bit 7 or 15. A store's lsu_rdata SHALL be 0.
REQ-026 A cycle counter SHALL run in REQ and WAIT. When the counter reaches WAIT_MAX, the FSM SHALL go to RESP with lsu_err=1 and lsu_rdata=0, and SHALL drop mem_req.
REQ-027 lsu_stall SHALL be (state!=IDLE && state!=RESP) || (state==IDLE && lsu_valid). lsu_stall SHALL be 0 in RESP.
REQ-028 Minimum latency SHALL be acceptance cycle 0, mem_req in cycle 1, and lsu_done in cycle 2 when mem_gnt and mem_rvalid both arrive in cycle 1. An error detected in IDLE SHALL produce lsu_done in cycle 1.
REQ-029 lsu_valid SHALL be ignored outside IDLE. mem_rvalid SHALL be ignored in IDLE and RESP. mem_gnt SHALL be ignored outside REQ.
REQ-030 The latched address and data SHALL be used for the whole operation; changes on lsu_* after acceptance SHALL have no effect.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, the counter to 0, and the outputs mem_req=0, mem_we=0, mem_be=0, lsu_done=0, lsu_err=0 and lsu_rdata=0.
REQ-032 Reset asserted mid-operation SHALL abandon the operation with no lsu_done pulse. A mem_rvalid arriving after reset SHALL be ignored.
REQ-033 After rst_n rises, the first rising clock edge SHALL accept a new operation.

Verification
REQ-034 LB, addr=0x1003, rdata=0x80FF_FF7F, gnt and rvalid in the same cycle -> mem_addr=0x1000, mem_be=1000, lsu_rdata=0xFFFF_FF80, done in cycle 2, err=0.
REQ-035 SH, addr=0x2002, wdata=0x1234_ABCD, gnt after 3 cycles, rvalid 2 cycles later -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_req held for 3 cycles, stall=1 throughout, single done pulse.
REQ-036 LW, addr=0x3001 -> no mem_req, done and err in cycle 1, lsu_rdata=0.
REQ-037 LHU, addr=0x0002, no gnt ever, WAIT_MAX=15 -> done and err after 15 REQ cycles, mem_req=0 in RESP.
REQ-038 rst_n pulsed low while in WAIT, then a late rvalid arrives -> mem_req=0 immediately, no done pulse, the next LW completes normally.
REQ-039 lsu_we=1 with funct3=100 -> illegal: err=1 and no memory access.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side and memory-side signal bundle for the load/store unit.
// master = the LSU itself, slave = the core/memory environment around it.
interface load_store_unit_if;
   logic        lsu_valid;
   logic        lsu_we;
   logic [2:0]  lsu_funct3;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic        lsu_stall;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic        lsu_err;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      input  lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
      output lsu_stall, lsu_done, lsu_rdata, lsu_err,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      output lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
      input  lsu_stall, lsu_done, lsu_rdata, lsu_err,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: one outstanding word-bus access with byte lanes,
// sign/zero extension, legality/alignment checks and a request/wait timeout.
module load_store_unit #(
   parameter int WAIT_MAX = 15
) (
   input logic               clk,
   input logic               rst_n,
   load_store_unit_if.master bus
);

   localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
   localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t        r_state;
   logic          r_we;
   logic [2:0]    r_funct3;
   logic [1:0]    r_addr_lo;
   logic [CW-1:0] r_count;
   logic          r_mem_req;
   logic [31:0]   r_mem_addr;
   logic [3:0]    r_mem_be;
   logic [31:0]   r_mem_wdata;
   logic          r_done;
   logic          r_err;
   logic [31:0]   r_rdata;

   logic [1:0]    w_size;
   logic          w_legal;
   logic          w_aligned;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic [31:0]   w_shifted;
   logic [31:0]   w_load;
   logic [31:0]   w_resp;

   // funct3[1:0] is the access size; funct3[2] is the unsigned flag, loads only
   always_comb begin
      w_size    = bus.lsu_funct3[1:0];
      w_legal   = (w_size != 2'b11) &&
                  (!bus.lsu_funct3[2] || (!bus.lsu_we && w_size != 2'b10));
      w_aligned = 1'b1;
      w_be      = 4'b1111;
      w_wdata   = bus.lsu_wdata;
      case (w_size)
         2'b00: begin
            w_be    = 4'b0001 << bus.lsu_addr[1:0];
            w_wdata = {4{bus.lsu_wdata[7:0]}};
         end
         2'b01: begin
            w_aligned = ~bus.lsu_addr[0];
            w_be      = 4'b0011 << bus.lsu_addr[1:0];
            w_wdata   = {2{bus.lsu_wdata[15:0]}};
         end
         default: begin
            w_aligned = (bus.lsu_addr[1:0] == 2'b00);
         end
      endcase
   end

   always_comb begin
      w_shifted = bus.mem_rdata >> {r_addr_lo, 3'b000};
      case (r_funct3)
         3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_load = {24'd0, w_shifted[7:0]};
         3'b101:  w_load = {16'd0, w_shifted[15:0]};
         default: w_load = w_shifted;
      endcase
      w_resp = r_we ? 32'd0 : w_load;
   end

   // A response in the last allowed cycle wins over the timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr_lo   <= 2'b00;
         r_count     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= 32'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= 32'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.lsu_valid) begin
                  if (w_legal && w_aligned) begin
                     r_we        <= bus.lsu_we;
                     r_funct3    <= bus.lsu_funct3;
                     r_addr_lo   <= bus.lsu_addr[1:0];
                     r_mem_addr  <= {bus.lsu_addr[31:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata;
                     r_mem_req   <= 1'b1;
                     r_count     <= '0;
                     r_err       <= 1'b0;
                     r_state     <= REQ;
                  end else begin
                     r_err   <= 1'b1;
                     r_rdata <= 32'd0;
                     r_done  <= 1'b1;
                     r_state <= RESP;
                  end
               end
            end
            REQ: begin
               if (bus.mem_gnt && bus.mem_rvalid) begin
                  r_mem_req <= 1'b0;
                  r_rdata   <= w_resp;
                  r_done    <= 1'b1;
                  r_state   <= RESP;
               end else if (r_count == LAST) begin
                  r_mem_req <= 1'b0;
                  r_err     <= 1'b1;
                  r_rdata   <= 32'd0;
                  r_done    <= 1'b1;
                  r_state   <= RESP;
               end else begin
                  r_count <= r_count + 1'b1;
                  if (bus.mem_gnt) begin
                     r_mem_req <= 1'b0;
                     r_state   <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (bus.mem_rvalid) begin
                  r_rdata <= w_resp;
                  r_done  <= 1'b1;
                  r_state <= RESP;
               end else if (r_count == LAST) begin
                  r_err   <= 1'b1;
                  r_rdata <= 32'd0;
                  r_done  <= 1'b1;
                  r_state <= RESP;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            RESP: begin
               r_err   <= 1'b0;
               r_rdata <= 32'd0;
               r_count <= '0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.lsu_stall = (r_state == REQ) || (r_state == WAIT) ||
                          ((r_state == IDLE) && bus.lsu_valid);
   assign bus.lsu_done  = r_done;
   assign bus.lsu_err   = r_err;
   assign bus.lsu_rdata = r_rdata;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_be    = r_mem_be;
   assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: drives core ops, plays the memory,
// and compares every completion against a queue of expected results.
module tb_load_store_unit;

   localparam int WAIT_MAX = 15;

   logic clk = 1'b0;
   logic rst_n;
   int   checkCount = 0;
   int   errorCount = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } expect_t;

   expect_t expQ[$];

   load_store_unit_if bus();

   load_store_unit #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Every completion pulse consumes one expected result
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.lsu_done === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_done", bus.lsu_done, 32'd0);
         end else begin
            expect_t e;
            e = expQ.pop_front();
            checkOutput("rdata", bus.lsu_rdata, e.rdata);
            checkOutput("err", bus.lsu_err, e.err);
         end
      end
   end

   // gntAt: REQ cycle carrying mem_gnt (0 = never); rvAfter: cycles from gnt to rvalid
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] memWord,
                                input int gntAt, input int rvAfter);
      logic        legal, aligned, ok, tmo, reqExp;
      logic [3:0]  be;
      logic [31:0] wd, ld;
      logic [7:0]  b8;
      logic [15:0] h16;
      int          a, rvAt, doneCyc;
      expect_t     e;

      a     = int'(addr[1:0]);
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      case (f3[1:0])
         2'd0:    aligned = 1'b1;
         2'd1:    aligned = (addr[0] == 1'b0);
         default: aligned = (a == 0);
      endcase
      ok  = legal && aligned;
      b8  = memWord[8*a +: 8];
      h16 = (a >= 2) ? memWord[31:16] : memWord[15:0];
      case (f3)
         3'd0:    ld = {{24{b8[7]}}, b8};
         3'd1:    ld = {{16{h16[15]}}, h16};
         3'd4:    ld = {24'd0, b8};
         3'd5:    ld = {16'd0, h16};
         default: ld = memWord;
      endcase
      case (f3[1:0])
         2'd0: begin
            be = 4'b0001 << a;
            wd = {4{wdata[7:0]}};
         end
         2'd1: begin
            be = 4'b0011 << a;
            wd = {2{wdata[15:0]}};
         end
         default: begin
            be = 4'b1111;
            wd = wdata;
         end
      endcase
      rvAt    = gntAt + rvAfter;
      tmo     = ok && (gntAt == 0 || rvAt > WAIT_MAX);
      doneCyc = !ok ? 1 : (tmo ? WAIT_MAX + 1 : rvAt + 1);
      e.rdata = (!ok || tmo || we) ? 32'd0 : ld;
      e.err   = !ok || tmo;
      expQ.push_back(e);

      @(posedge clk); #1;
      bus.lsu_valid  = 1'b1;
      bus.lsu_we     = we;
      bus.lsu_funct3 = f3;
      bus.lsu_addr   = addr;
      bus.lsu_wdata  = wdata;
      @(negedge clk);
      checkOutput("stall_accept", bus.lsu_stall, 32'd1);

      for (int c = 1; c <= doneCyc; c++) begin
         @(posedge clk); #1;
         bus.lsu_valid  = 1'b0;
         bus.lsu_we     = 1'($urandom);
         bus.lsu_funct3 = 3'($urandom);
         bus.lsu_addr   = $urandom;
         bus.lsu_wdata  = $urandom;
         bus.mem_gnt    = ok && (c == gntAt);
         bus.mem_rvalid = ok && (gntAt != 0) && (c == rvAt);
         bus.mem_rdata  = bus.mem_rvalid ? memWord : $urandom;
         @(negedge clk);
         if (c < doneCyc) begin
            reqExp = ok && (gntAt == 0 || c <= gntAt);
            checkOutput("stall_busy", bus.lsu_stall, 32'd1);
            checkOutput("done_early", bus.lsu_done, 32'd0);
            checkOutput("mem_req", bus.mem_req, reqExp);
            if (reqExp) begin
               checkOutput("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
               checkOutput("mem_be", bus.mem_be, be);
               checkOutput("mem_we", bus.mem_we, we);
               if (we) checkOutput("mem_wdata", bus.mem_wdata, wd);
            end
         end else begin
            checkOutput("done_pulse", bus.lsu_done, 32'd1);
            checkOutput("stall_resp", bus.lsu_stall, 32'd0);
            checkOutput("mem_req_resp", bus.mem_req, 32'd0);
         end
      end

      @(posedge clk); #1;
      bus.mem_gnt    = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      @(negedge clk);
      checkOutput("done_single", bus.lsu_done, 32'd0);
      @(posedge clk); #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      checkOutput("idle_ignore_mem", {31'd0, bus.mem_req | bus.lsu_done}, 32'd0);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.lsu_valid  = 1'b0;
      bus.lsu_we     = 1'b0;
      bus.lsu_funct3 = 3'd0;
      bus.lsu_addr   = 32'd0;
      bus.lsu_wdata  = 32'd0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'd0;
      #2;
      checkOutput("rst_mem_req", bus.mem_req, 32'd0);
      checkOutput("rst_mem_we", bus.mem_we, 32'd0);
      checkOutput("rst_mem_be", bus.mem_be, 32'd0);
      checkOutput("rst_done", bus.lsu_done, 32'd0);
      checkOutput("rst_err", bus.lsu_err, 32'd0);
      checkOutput("rst_rdata", bus.lsu_rdata, 32'd0);
      checkOutput("rst_stall", bus.lsu_stall, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_FF7F, 1, 0);
      applyStimulus(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,         3, 2);
      applyStimulus(1'b0, 3'b010, 32'h0000_3001, 32'h0,         32'h5555_AAAA, 1, 0);
      applyStimulus(1'b0, 3'b101, 32'h0000_0002, 32'h0,         32'h1234_5678, 0, 0);
      applyStimulus(1'b1, 3'b100, 32'h0000_4000, 32'hFFFF_FFFF, 32'h0,         1, 0);
      applyStimulus(1'b0, 3'b100, 32'h0000_5001, 32'h0,         32'h1234_F678, 1, 0);
      applyStimulus(1'b0, 3'b001, 32'h0000_6002, 32'h0,         32'h8001_1111, 2, 0);
      applyStimulus(1'b0, 3'b101, 32'h0000_6000, 32'h0,         32'h1234_9ABC, 1, 1);
      applyStimulus(1'b1, 3'b000, 32'h0000_7001, 32'h0000_00AB, 32'h0,         1, 0);
      applyStimulus(1'b1, 3'b010, 32'h0000_7004, 32'hDEAD_BEEF, 32'h0,         2, 3);
      applyStimulus(1'b0, 3'b010, 32'h0000_8000, 32'h0,         32'hCAFE_F00D, 2, 1);
      applyStimulus(1'b0, 3'b001, 32'h0000_9001, 32'h0,         32'h0,         1, 0);
      applyStimulus(1'b0, 3'b011, 32'h0000_9000, 32'h0,         32'h0,         1, 0);
      applyStimulus(1'b0, 3'b000, 32'h0000_A002, 32'h0,         32'h0044_0000, 14, 1);
      applyStimulus(1'b0, 3'b010, 32'h0000_B000, 32'h0,         32'h1111_2222, 14, 2);

      // Abandon a load in WAIT with reset, then deliver its response late
      @(posedge clk); #1;
      bus.lsu_valid  = 1'b1;
      bus.lsu_we     = 1'b0;
      bus.lsu_funct3 = 3'b010;
      bus.lsu_addr   = 32'h0000_C000;
      @(posedge clk); #1;
      bus.lsu_valid = 1'b0;
      bus.mem_gnt   = 1'b1;
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0;
      @(negedge clk);
      checkOutput("wait_stall", bus.lsu_stall, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("arst_mem_req", bus.mem_req, 32'd0);
      checkOutput("arst_mem_be", bus.mem_be, 32'd0);
      checkOutput("arst_stall", bus.lsu_stall, 32'd0);
      checkOutput("arst_done", bus.lsu_done, 32'd0);
      @(posedge clk); #1;
      rst_n          = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h0BAD_0BAD;
      @(negedge clk);
      checkOutput("late_rvalid_done", bus.lsu_done, 32'd0);
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      checkOutput("late_rvalid_idle", {31'd0, bus.lsu_done | bus.lsu_stall}, 32'd0);

      applyStimulus(1'b0, 3'b010, 32'h0000_D000, 32'h0, 32'h0123_4567, 1, 0);

      repeat (2) @(negedge clk);
      checkOutput("queue_empty", expQ.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
